// File: rtl/tlc_param_ctrl.sv
// rtl/tlc_param_ctrl.sv - parametrised highway/farm-road traffic light controller
//
// Purpose: Moore FSM that alternates highway and farm-road green. It owns its
// dwell timer, synchronises the farm sensor, latches pedestrian requests and
// extends farm green while the sensor stays active, up to a ceiling.
// All durations are in clock cycles.
// Optional build macro: TLC_NIGHT_FLASH_EN adds a night flash state (111).
//
// Ports:
//   Clk, Rst       clock, synchronous active-high reset
//   farmSensor     raw asynchronous vehicle sensor
//   pedReq         pedestrian button (Clk-synchronous, any width)
//   nightMode      night flash request (only used with TLC_NIGHT_FLASH_EN)
//   state, count   debug: FSM state and dwell timer
//   farmSync       debug: synchronised sensor
//   highwaySignal  lamps: 11 green, 10 yellow, 01 red, 00 dark
//   farmSignal     lamps, same encoding
//   walk           pedestrian walk lamp
//   pedPending     latched, unserved pedestrian request
module tlc_param_ctrl #(
  parameter int CNT_W      = 31,
  parameter int T_ALLRED   = 50000000,
  parameter int T_YELLOW   = 150000000,
  parameter int T_HWY_MIN  = 1500000000,
  parameter int T_FARM_MIN = 150000000,
  parameter int T_FARM_EXT = 750000000
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             farmSensor,
  input  logic             pedReq,
  input  logic             nightMode,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] count,
  output logic             farmSync,
  output logic [1:0]       highwaySignal,
  output logic [1:0]       farmSignal,
  output logic             walk,
  output logic             pedPending
);

  localparam logic [2:0] S_INIT        = 3'b000;
  localparam logic [2:0] S_HWY_GREEN   = 3'b001;
  localparam logic [2:0] S_HWY_YELLOW  = 3'b010;
  localparam logic [2:0] S_ALLRED_A    = 3'b011;
  localparam logic [2:0] S_FARM_GREEN  = 3'b100;
  localparam logic [2:0] S_FARM_YELLOW = 3'b101;
  localparam logic [2:0] S_ALLRED_B    = 3'b110;
  localparam logic [2:0] S_FLASH       = 3'b111;

  localparam logic [1:0] L_GREEN  = 2'b11;
  localparam logic [1:0] L_YELLOW = 2'b10;
  localparam logic [1:0] L_RED    = 2'b01;
  localparam logic [1:0] L_DARK   = 2'b00;

  // Terminal count values: a dwell of T leaves on count == T-1.
  localparam logic [CNT_W-1:0] LAST_ALLRED   = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] LAST_YELLOW   = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LAST_HWY      = CNT_W'(T_HWY_MIN - 1);
  localparam logic [CNT_W-1:0] LAST_FARM_MIN = CNT_W'(T_FARM_MIN - 1);
  localparam logic [CNT_W-1:0] LAST_FARM_MAX =
    CNT_W'(longint'(T_FARM_MIN) + longint'(T_FARM_EXT) - 64'sd1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sync1_q, sync2_q;
  logic             ped_q, ped_d;
  logic             phase_q, phase_d;

`ifndef TLC_NIGHT_FLASH_EN
  logic unused_night_mode;
  assign unused_night_mode = nightMode;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:
        if (count_q == LAST_ALLRED) state_d = sync2_q ? S_FARM_GREEN : S_HWY_GREEN;
      S_HWY_GREEN: begin
        // count saturates at LAST_HWY, so equality also covers "at least".
        if (count_q == LAST_HWY && (sync2_q || ped_q)) state_d = S_HWY_YELLOW;
`ifdef TLC_NIGHT_FLASH_EN
        if (nightMode) state_d = S_FLASH;
`endif
      end
      S_HWY_YELLOW:
        if (count_q == LAST_YELLOW) state_d = S_ALLRED_A;
      S_ALLRED_A:
        if (count_q == LAST_ALLRED) state_d = S_FARM_GREEN;
      S_FARM_GREEN:
        if (count_q == LAST_FARM_MAX || (count_q >= LAST_FARM_MIN && !sync2_q))
          state_d = S_FARM_YELLOW;
      S_FARM_YELLOW:
        if (count_q == LAST_YELLOW) state_d = S_ALLRED_B;
      S_ALLRED_B:
        if (count_q == LAST_ALLRED) state_d = S_HWY_GREEN;
`ifdef TLC_NIGHT_FLASH_EN
      S_FLASH:
        if (!nightMode) state_d = S_INIT;
`endif
      default: state_d = S_INIT;
    endcase
  end

  // Dwell timer, phase bit and pedestrian latch
  always_comb begin
    if (state_d != state_q)
      count_d = '0;
    else if (state_q == S_HWY_GREEN && count_q == LAST_HWY)
      count_d = count_q;
`ifdef TLC_NIGHT_FLASH_EN
    else if (state_q == S_FLASH && count_q == LAST_ALLRED)
      count_d = '0;
`endif
    else
      count_d = count_q + 1'b1;

    // Phase restarts at 0 on every FLASH entry and toggles on each timer wrap.
    if (state_q == S_FLASH && state_d == S_FLASH)
      phase_d = phase_q ^ (count_q == LAST_ALLRED);
    else
      phase_d = 1'b0;

    // Clearing on entry into FARM_GREEN makes the latch read 0 from the
    // first farm-green cycle; the clear beats a same-cycle set.
    if (state_d == S_FARM_GREEN)
      ped_d = 1'b0;
    else
      ped_d = ped_q | (pedReq && state_q != S_FARM_GREEN);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_INIT;
      count_q <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      ped_q   <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sync1_q <= farmSensor;
      sync2_q <= sync1_q;
      ped_q   <= ped_d;
      phase_q <= phase_d;
    end
  end

  // Moore lamp decode
  always_comb begin
    highwaySignal = L_RED;
    farmSignal    = L_RED;
    walk          = 1'b0;
    case (state_q)
      S_HWY_GREEN:   highwaySignal = L_GREEN;
      S_HWY_YELLOW:  highwaySignal = L_YELLOW;
      S_FARM_GREEN: begin
        farmSignal = L_GREEN;
        walk       = 1'b1;
      end
      S_FARM_YELLOW: farmSignal = L_YELLOW;
`ifdef TLC_NIGHT_FLASH_EN
      S_FLASH: begin
        highwaySignal = phase_q ? L_DARK : L_YELLOW;
        farmSignal    = phase_q ? L_DARK : L_RED;
      end
`endif
      default: ;
    endcase
  end

  assign state      = state_q;
  assign count      = count_q;
  assign farmSync   = sync2_q;
  assign pedPending = ped_q;

endmodule

// File: tb/tb_tlc_param_ctrl.sv
// tb/tb_tlc_param_ctrl.sv - self-checking bench for tlc_param_ctrl
module tb_tlc_param_ctrl;
  localparam int CW = 31;
  localparam int TA = 2;
  localparam int TY = 3;
  localparam int TH = 10;
  localparam int TF = 4;
  localparam int TE = 6;
`ifdef TLC_NIGHT_FLASH_EN
  localparam bit NIGHT = 1'b1;
`else
  localparam bit NIGHT = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic farmSensor = 1'b0;
  logic pedReq = 1'b0;
  logic nightMode = 1'b0;
  logic [2:0] state;
  logic [CW-1:0] count;
  logic farmSync;
  logic [1:0] highwaySignal, farmSignal;
  logic walk, pedPending;

  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  tlc_param_ctrl #(
    .CNT_W(CW), .T_ALLRED(TA), .T_YELLOW(TY), .T_HWY_MIN(TH),
    .T_FARM_MIN(TF), .T_FARM_EXT(TE)
  ) dut (
    .Clk(Clk), .Rst(Rst), .farmSensor(farmSensor), .pedReq(pedReq),
    .nightMode(nightMode), .state(state), .count(count), .farmSync(farmSync),
    .highwaySignal(highwaySignal), .farmSignal(farmSignal), .walk(walk),
    .pedPending(pedPending)
  );

  // Reference model: named phases, uncapped elapsed-cycle counter, 2-deep sensor history.
  typedef enum {P_INIT, P_HG, P_HY, P_AA, P_FG, P_FY, P_AB, P_FL} phase_e;
  phase_e m_ph = P_INIT;
  int m_el = 0;
  bit m_s1 = 0, m_s2 = 0, m_ped = 0, m_fl = 0;

  task automatic model_clock();
    phase_e nx;
    if (Rst) begin
      m_ph = P_INIT; m_el = 0; m_s1 = 0; m_s2 = 0; m_ped = 0; m_fl = 0;
      return;
    end
    nx = m_ph;
    case (m_ph)
      P_INIT: if (m_el == TA - 1) nx = m_s2 ? P_FG : P_HG;
      P_HG: begin
        if (NIGHT && nightMode) nx = P_FL;
        else if (m_el >= TH - 1 && (m_s2 || m_ped)) nx = P_HY;
      end
      P_HY: if (m_el == TY - 1) nx = P_AA;
      P_AA: if (m_el == TA - 1) nx = P_FG;
      P_FG: if (m_el == TF + TE - 1 || (m_el >= TF - 1 && !m_s2)) nx = P_FY;
      P_FY: if (m_el == TY - 1) nx = P_AB;
      P_AB: if (m_el == TA - 1) nx = P_HG;
      P_FL: if (!nightMode) nx = P_INIT;
      default: nx = P_INIT;
    endcase
    m_ped = (nx == P_FG) ? 1'b0 : (m_ped | (pedReq && m_ph != P_FG));
    m_s2 = m_s1;
    m_s1 = farmSensor;
    if (nx != m_ph) begin
      m_el = 0; m_fl = 0;
    end else if (m_ph == P_FL) begin
      m_el++;
      if (m_el == TA) begin m_el = 0; m_fl = !m_fl; end
    end else begin
      m_el++;
    end
    m_ph = nx;
  endtask

  task automatic cmp(string name, logic [2:0] st, logic [CW-1:0] cnt, logic fs,
                     logic [1:0] hw, logic [1:0] fm, logic wk, logic pp);
    vectors++;
    if (state !== st || count !== cnt || farmSync !== fs || highwaySignal !== hw ||
        farmSignal !== fm || walk !== wk || pedPending !== pp) begin
      miscompares++;
      $display("FAIL %s t=%0t got st=%b cnt=%0d fs=%b hw=%b fm=%b wk=%b pp=%b required st=%b cnt=%0d fs=%b hw=%b fm=%b wk=%b pp=%b",
               name, $time, state, count, farmSync, highwaySignal, farmSignal, walk, pedPending,
               st, cnt, fs, hw, fm, wk, pp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic check_model();
    logic [2:0] st;
    logic [1:0] hw, fm;
    int c;
    case (m_ph)
      P_INIT: begin st = 3'd0; hw = 2'b01; fm = 2'b01; end
      P_HG:   begin st = 3'd1; hw = 2'b11; fm = 2'b01; end
      P_HY:   begin st = 3'd2; hw = 2'b10; fm = 2'b01; end
      P_AA:   begin st = 3'd3; hw = 2'b01; fm = 2'b01; end
      P_FG:   begin st = 3'd4; hw = 2'b01; fm = 2'b11; end
      P_FY:   begin st = 3'd5; hw = 2'b01; fm = 2'b10; end
      P_AB:   begin st = 3'd6; hw = 2'b01; fm = 2'b01; end
      default: begin st = 3'd7; hw = m_fl ? 2'b00 : 2'b10; fm = m_fl ? 2'b00 : 2'b01; end
    endcase
    c = (m_ph == P_HG && m_el > TH - 1) ? TH - 1 : m_el;
    cmp("model", st, CW'(c), m_s2, hw, fm, m_ph == P_FG, m_ped);
  endtask

  task automatic step(bit r, bit f, bit p, bit n);
    Rst = r; farmSensor = f; pedReq = p; nightMode = n;
    @(posedge Clk);
    model_clock();
    @(negedge Clk);
    check_model();
  endtask

  // Step until state==code (bounded); a timeout shows up as a failed check.
  task automatic wait_state(logic [2:0] code, bit f, bit p, string name);
    int n = 0;
    while (state !== code && n < 200) begin
      step(0, f, p, 0);
      n++;
    end
    check_int(name, int'(state), int'(code));
  endtask

  // Count cycles spent in the current state; sensor high for the first 'hold' cycles.
  task automatic dwell(logic [2:0] code, int exp, int hold, string name);
    int n = 0;
    while (state === code && n < 200) begin
      step(0, n < hold, 0, 0);
      n++;
    end
    check_int(name, n, exp);
  endtask

  typedef struct {
    bit rst; bit pr;
    logic [2:0] st; int cnt; logic [1:0] hw; logic [1:0] fm; bit wk; bit pp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Reset, INIT dwell, highway green, pedestrian-only service cycle.
    tbl.push_back('{1, 0, 3'd0, 0, 2'b01, 2'b01, 0, 0});
    tbl.push_back('{0, 0, 3'd0, 1, 2'b01, 2'b01, 0, 0});
    for (int i = 0; i < 4; i++) tbl.push_back('{0, 0, 3'd1, i, 2'b11, 2'b01, 0, 0});
    tbl.push_back('{0, 1, 3'd1, 4, 2'b11, 2'b01, 0, 1});
    for (int i = 5; i < 10; i++) tbl.push_back('{0, 0, 3'd1, i, 2'b11, 2'b01, 0, 1});
    for (int i = 0; i < 3; i++) tbl.push_back('{0, 0, 3'd2, i, 2'b10, 2'b01, 0, 1});
    for (int i = 0; i < 2; i++) tbl.push_back('{0, 0, 3'd3, i, 2'b01, 2'b01, 0, 1});
    for (int i = 0; i < 4; i++) tbl.push_back('{0, 0, 3'd4, i, 2'b01, 2'b11, 1, 0});
    for (int i = 0; i < 3; i++) tbl.push_back('{0, 0, 3'd5, i, 2'b01, 2'b10, 0, 0});
    for (int i = 0; i < 2; i++) tbl.push_back('{0, 0, 3'd6, i, 2'b01, 2'b01, 0, 0});
    tbl.push_back('{0, 0, 3'd1, 0, 2'b11, 2'b01, 0, 0});

    @(negedge Clk);
    foreach (tbl[i]) begin
      step(tbl[i].rst, 0, tbl[i].pr, 0);
      cmp("table", tbl[i].st, CW'(tbl[i].cnt), 1'b0, tbl[i].hw, tbl[i].fm, tbl[i].wk, tbl[i].pp);
    end

    // Highway green holds with no request; count sticks at T_HWY_MIN-1.
    for (int i = 0; i < 55; i++) step(0, 0, 0, 0);
    cmp("hwy_hold", 3'd1, CW'(TH - 1), 1'b0, 2'b11, 2'b01, 1'b0, 1'b0);

    // Sensor raised and held: yields on the 3rd edge, farm green extends to the ceiling.
    begin
      int n = 0;
      while (state === 3'd1 && n < 20) begin
        step(0, 1, 0, 0);
        n++;
      end
      check_int("sensor_to_yellow_edges", n, 3);
    end
    dwell(3'd2, TY, 1000, "hwy_yellow_len");
    dwell(3'd3, TA, 1000, "allred_a_len");
    dwell(3'd4, TF + TE, 1000, "farm_green_max_len");
    dwell(3'd5, TY, 1000, "farm_yellow_len");
    dwell(3'd6, TA, 1000, "allred_b_len");
    check_int("back_to_hwy", int'(state), 1);

    // Sensor dropped early in farm green: minimum farm green only.
    wait_state(3'd4, 1, 0, "reach_fg_2");
    dwell(3'd4, TF, 1, "farm_green_drop_len");

    // Reset on the 2nd farm-green cycle.
    wait_state(3'd1, 0, 0, "reach_hg_3");
    step(0, 0, 1, 0);
    wait_state(3'd4, 0, 0, "reach_fg_3");
    step(0, 0, 0, 0);
    check_int("fg_second_cycle", int'(count), 1);
    step(1, 0, 1, 0);
    cmp("reset_mid_fg", 3'd0, '0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0);
    step(0, 0, 0, 0);

`ifdef TLC_NIGHT_FLASH_EN
    wait_state(3'd1, 0, 0, "reach_hg_night");
    step(0, 0, 0, 1);
    cmp("flash_entry", 3'd7, '0, 1'b0, 2'b10, 2'b01, 1'b0, 1'b0);
    for (int k = 1; k < 8; k++) begin
      bit ph;
      ph = ((k / 2) % 2) == 1;
      step(0, 0, 0, 1);
      cmp("flash_run", 3'd7, CW'(k % 2), 1'b0, ph ? 2'b00 : 2'b10, ph ? 2'b00 : 2'b01,
          1'b0, 1'b0);
    end
    step(0, 0, 0, 0);
    cmp("flash_exit", 3'd0, '0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0);
`endif

    // Randomised run against the model.
    begin
      bit fs_r = 0, nm_r = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 15) == 0) fs_r = !fs_r;
        if ($urandom_range(0, 39) == 0) nm_r = !nm_r;
        step($urandom_range(0, 199) == 0, fs_r, $urandom_range(0, 19) == 0, nm_r);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tlc_param_ctrl.md
Name: tlc_param_ctrl

Overview:
Parametrised highway/farm-road traffic light controller for the next lab generation.
- Owns its dwell timer, so no external counter is needed.
- Synchronises the raw farm sensor internally.
- Adds a latched pedestrian request with a walk output.
- Extends farm green while the sensor stays active, up to a ceiling.
- All durations are parameters in clock cycles, so the block runs at 50 MHz on the board and with tiny values in simulation.

Parameters:
CNT_W, 31, dwell-timer width
T_ALLRED, 50000000, all-red clearance dwell (cycles)
T_YELLOW, 150000000, yellow dwell, both roads
T_HWY_MIN, 1500000000, minimum highway green
T_FARM_MIN, 150000000, minimum farm green
T_FARM_EXT, 750000000, maximum extra farm green while sensor held

Ports:
Clk  input  1  clock
Rst  input  1  synchronous, active-high reset
farmSensor  input  1  raw asynchronous vehicle sensor
pedReq  input  1  pedestrian button, synchronous to Clk, any pulse width
nightMode  input  1  night flash request; used only with TLC_NIGHT_FLASH_EN
state  output  3  current state (debug)
count  output  CNT_W  dwell timer (debug)
farmSync  output  1  synchronised sensor (debug)
highwaySignal  output  2  11 green, 10 yellow, 01 red, 00 dark
farmSignal  output  2  same encoding
walk  output  1  pedestrian walk lamp
pedPending  output  1  latched, unserved pedestrian request

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Rst is synchronous and active-high on Clk.
- Reset values:
  - state=INIT (000), count=0, sync flops=0, pedPending=0.
  - Outputs during reset: highwaySignal=01, farmSignal=01, walk=0.
  - Reset mid-operation returns to INIT at the next edge, regardless of state.
- Synchroniser:
  - farmSensor passes through two flops to produce farmSync.
  - Latency is 2 cycles. The FSM uses only farmSync.
- Outputs: lamp outputs and walk are Moore decodes of state only.
- Timer:
  - count is 0 on the first cycle of every state and increments by 1 per cycle.
  - "Dwell T" means the FSM leaves on the cycle where count==T-1, so the state lasts exactly T cycles. count is 0 on the following cycle.
  - In HWY_GREEN, count saturates at T_HWY_MIN-1 and never wraps.
- Parameter constraints:
  - All T_* >= 1.
  - T_FARM_MIN+T_FARM_EXT <= 2^CNT_W.
  - Values outside these constraints are unsupported.
- States, with (highway, farm) lamps and transitions:
  - INIT 000 (red, red): dwell T_ALLRED, then FARM_GREEN if farmSync else HWY_GREEN.
  - HWY_GREEN 001 (green, red): leave when count==T_HWY_MIN-1 and (farmSync or pedPending) -> HWY_YELLOW. Otherwise hold indefinitely.
  - HWY_YELLOW 010 (yellow, red): dwell T_YELLOW -> ALLRED_A.
  - ALLRED_A 011 (red, red): dwell T_ALLRED -> FARM_GREEN.
  - FARM_GREEN 100 (red, green), walk=1:
    - Leave when count==T_FARM_MIN+T_FARM_EXT-1 -> FARM_YELLOW.
    - Or leave when count>=T_FARM_MIN-1 and farmSync==0 -> FARM_YELLOW.
    - A pedestrian-only request therefore gets exactly T_FARM_MIN.
  - FARM_YELLOW 101 (red, yellow): dwell T_YELLOW -> ALLRED_B.
  - ALLRED_B 110 (red, red): dwell T_ALLRED -> HWY_GREEN, unconditionally. Farm traffic never pre-empts a full highway minimum green.
  - 111 without the macro: illegal, all red, -> INIT next cycle.
- pedPending:
  - Set on any cycle with pedReq=1 and state!=FARM_GREEN.
  - Cleared on every FARM_GREEN cycle. pedReq during FARM_GREEN is ignored.
  - If set and clear conditions hit the same cycle, the FARM_GREEN clear wins.
- Simultaneous events: farmSync and pedPending together are a single request to HWY_GREEN; no extra cycles are added.

Optional Feature:
Macro TLC_NIGHT_FLASH_EN.
- Defined:
  - nightMode=1 in HWY_GREEN (any count) -> FLASH (111) next cycle.
  - In FLASH, count runs 0..T_ALLRED-1 and wraps to 0.
  - A phase bit toggles on each wrap, starting at 0 on entry. Phase 0 shows highwaySignal=10 and farmSignal=01; phase 1 shows both 00. walk=0.
  - nightMode=0 in FLASH -> INIT next cycle.
  - pedPending still latches in FLASH but is not served until normal operation resumes.
- Undefined:
  - nightMode is ignored; 111 is illegal as described above.
  - Port list is identical in both builds.

Test Plan:
Common parameters: T_ALLRED=2, T_YELLOW=3, T_HWY_MIN=10, T_FARM_MIN=4, T_FARM_EXT=6.
1. Rst 1 cycle, sensors low -> INIT for 2 cycles (01/01), then HWY_GREEN held for 50+ cycles; count sticks at 9.
2. farmSensor raised after count==9 and held -> HWY_YELLOW on the 3rd edge after the rise; yellow 3 cycles, all-red 2; FARM_GREEN exactly 10 cycles; FARM_YELLOW 3; ALLRED_B 2; then HWY_GREEN.
3. farmSensor dropped 2 cycles into FARM_GREEN -> FARM_GREEN lasts exactly 4 cycles.
4. 1-cycle pedReq in HWY_GREEN (count=3), sensor low -> pedPending=1; yield at count==9; FARM_GREEN 4 cycles with walk=1; pedPending=0 from the first FARM_GREEN cycle.
5. Rst asserted on the 2nd FARM_GREEN cycle -> next edge: state=000, count=0, lamps 01/01, walk=0, pedPending=0.
6. Built with TLC_NIGHT_FLASH_EN: nightMode=1 in HWY_GREEN -> 111; highway alternates 10/00 every 2 cycles, farm alternates 01/00. nightMode=0 -> INIT next cycle.
